usb_rx_data_buffer: RTL

//  Packet-aware receive FIFO directly downstream of the USB RX core. Stores each byte presented on the
//  rx_packet_data/store_rx_packet_data strobe and tracks the rx_packet status code to frame DATA packets.

---
 rtl/usb_rx_pkg.sv | 23 ++
 rtl/usb_rx_buffer_ram.sv | 30 +++
 rtl/usb_rx_data_buffer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types for the USB receive path: RX status codes and receive-buffer FSM states.
package usb_rx_pkg;

   typedef enum logic [2:0] {
      RX_NONE  = 3'd0,
      RX_IN    = 3'd1,
      RX_OUT   = 3'd2,
      RX_DATA  = 3'd3,
      RX_ACK   = 3'd4,
      RX_NAK   = 3'd5,
      RX_STALL = 3'd6,
      RX_ERR   = 3'd7
   } rx_pkt_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RECV     = 3'd1,
      COMMIT   = 3'd2,
      ROLLBACK = 3'd3,
      DISCARD  = 3'd4
   } buf_state_t;

endpackage

// File: rtl/usb_rx_buffer_ram.sv
// DEPTH x 8 byte store for the receive buffer: one synchronous write port, one asynchronous read port.
module usb_rx_buffer_ram #(
   parameter  int unsigned DEPTH = 64,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // Cleared on reset so the fall-through head byte reads 8'h00 out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/usb_rx_data_buffer.sv
// Packet-aware receive FIFO: bytes of a DATA packet become readable only once the packet ends
// cleanly; errored or overflowed packets are rolled back to the last commit point.
module usb_rx_data_buffer
   import usb_rx_pkg::*;
#(
   parameter  int unsigned DEPTH = 64,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       rx_packet,
   input  logic             store_rx_packet_data,
   input  logic [7:0]       rx_packet_data,
   input  logic             get_rx_data,
   input  logic             flush,
   output logic [7:0]       rx_data,
   output logic             rx_data_valid,
   output logic [PTR_W:0]   buffer_occupancy,
   output logic             packet_done,
   output logic             packet_error,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   rx_pkt_t     pkt;
   buf_state_t  state;
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] cm_ptr;
   logic [PTR_W:0] rd_ptr;
   logic [PTR_W:0] fill;
   logic [PTR_W:0] occ;
   logic           bad_pkt;
   logic           full;
   logic           in_data;
   logic           accept;
   logic           drop;

   assign pkt     = rx_pkt_t'(rx_packet);
   assign in_data = (pkt == RX_DATA);

   // Full uses the read pointer before any same-cycle pop.
   assign fill    = wr_ptr - rd_ptr;
   assign full    = (fill == FULL_CNT);
   assign occ     = cm_ptr - rd_ptr;

   assign accept  = (state == RECV) && store_rx_packet_data && !full && !flush;
   assign drop    = (state == RECV) && store_rx_packet_data && full;

   assign buffer_occupancy = occ;
   assign rx_data_valid    = (occ != '0);

   usb_rx_buffer_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (accept),
      .waddr (wr_ptr[PTR_W-1:0]),
      .wdata (rx_packet_data),
      .raddr (rd_ptr[PTR_W-1:0]),
      .rdata (rx_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         cm_ptr       <= '0;
         rd_ptr       <= '0;
         bad_pkt      <= 1'b0;
         packet_done  <= 1'b0;
         packet_error <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else if (flush) begin
         state        <= in_data ? DISCARD : IDLE;
         wr_ptr       <= '0;
         cm_ptr       <= '0;
         rd_ptr       <= '0;
         bad_pkt      <= 1'b0;
         packet_done  <= 1'b0;
         packet_error <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         packet_done  <= 1'b0;
         packet_error <= 1'b0;

         if (get_rx_data) begin
            if (occ != '0) begin
               rd_ptr <= rd_ptr + 1'b1;
            end else begin
               underflow <= 1'b1;
            end
         end

         unique case (state)
            IDLE: begin
               bad_pkt <= 1'b0;
               if (in_data) begin
                  state <= RECV;
               end
            end

            RECV: begin
               if (accept) begin
                  wr_ptr <= wr_ptr + 1'b1;
               end
               if (drop) begin
                  overflow <= 1'b1;
                  bad_pkt  <= 1'b1;
               end
               // A byte dropped in the exit cycle still poisons the packet.
               if (!in_data) begin
                  if (pkt == RX_ERR || bad_pkt || drop) begin
                     state        <= ROLLBACK;
                     packet_error <= 1'b1;
                  end else begin
                     state       <= COMMIT;
                     packet_done <= 1'b1;
                  end
               end
            end

            COMMIT: begin
               cm_ptr <= wr_ptr;
               state  <= IDLE;
            end

            ROLLBACK: begin
               wr_ptr <= cm_ptr;
               state  <= IDLE;
            end

            DISCARD: begin
               if (!in_data) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
